// File: rtl/accel_isa_pkg.sv
// Shared accelerator ISA definitions: opcodes, instruction field layout,
// widths, and the host-driver state/descriptor types.
package accel_isa_pkg;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 32;
    localparam int IDX_W   = 4;
    localparam int INSTR_W = 64;
    localparam int LEN_W   = 8;
    localparam int CNT_W   = 5;

    localparam int OP_LSB   = 60;
    localparam int ADDR_LSB = 45;
    localparam int PAD_W    = ADDR_LSB - DATA_W;

    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(16);

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_LOAD_INP  = 4'd1,
        OP_LOAD_WT   = 4'd2,
        OP_COMPUTE   = 4'd3,
        OP_READ_OUT  = 4'd4,
        OP_ACC_RESET = 4'd5
    } opcode_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACC_RST,
        S_LOAD_INP,
        S_LOAD_WT,
        S_COMPUTE,
        S_COMP_WAIT,
        S_READ_ISSUE,
        S_READ_WAIT,
        S_RES_HOLD
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] inp_base;
        logic [ADDR_W-1:0] wt_base;
        logic [LEN_W-1:0]  len;
        logic [CNT_W-1:0]  out_cnt;
    } job_t;

    // The output buffer has 16 entries; larger requests read all of it.
    function automatic logic [CNT_W-1:0] clip_out_cnt(input logic [CNT_W-1:0] n);
        return (n > MAX_OUT) ? MAX_OUT : n;
    endfunction

endpackage

// File: rtl/accel_host_driver_if.sv
// Host/accelerator bundle for the host driver: job descriptor, operand
// stream, result stream and the accelerator instruction/result ports.
interface accel_host_driver_if;
    import accel_isa_pkg::*;

    logic                job_valid;
    logic                job_ready;
    logic [ADDR_W-1:0]   job_inp_base;
    logic [ADDR_W-1:0]   job_wt_base;
    logic [LEN_W-1:0]    job_len;
    logic [CNT_W-1:0]    job_out_cnt;

    logic                din_valid;
    logic                din_ready;
    logic [DATA_W-1:0]   din_data;

    logic [INSTR_W-1:0]  acc_instr;
    logic [INSTR_W-1:0]  acc_result;

    logic                res_valid;
    logic                res_ready;
    logic [INSTR_W-1:0]  res_data;

    logic                busy;

    modport slave (
        input  job_valid, job_inp_base, job_wt_base, job_len, job_out_cnt,
        output job_ready,
        input  din_valid, din_data,
        output din_ready,
        output acc_instr,
        input  acc_result,
        output res_valid, res_data,
        input  res_ready,
        output busy
    );

    modport master (
        output job_valid, job_inp_base, job_wt_base, job_len, job_out_cnt,
        input  job_ready,
        output din_valid, din_data,
        input  din_ready,
        input  acc_instr,
        output acc_result,
        input  res_valid, res_data,
        output res_ready,
        input  busy
    );

endinterface

// File: rtl/accel_host_driver_instr_pack.sv
// Packs opcode/address/data into the 64-bit accelerator instruction word.
module accel_host_driver_instr_pack
    import accel_isa_pkg::*;
(
    input  opcode_t              op_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [DATA_W-1:0]    data_i,
    output logic [INSTR_W-1:0]   word_o
);

    assign word_o = {op_i, addr_i, {PAD_W{1'b0}}, data_i};

endmodule

// File: rtl/accel_host_driver.sv
// Host-side sequencer: takes one job, streams operands into the accelerator,
// runs COMPUTE, then reads the output buffer back one word at a time.
module accel_host_driver
    import accel_isa_pkg::*;
#(
    parameter int ARR_SIZE     = 4,
    parameter int COMPUTE_WAIT = 3 * ARR_SIZE,
    parameter int RD_LAT       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    accel_host_driver_if.slave   bus
);

    localparam logic [15:0] CW_LAST = 16'(COMPUTE_WAIT - 1);
    localparam logic [15:0] RD_LAST = 16'(RD_LAT);

    state_t              state_q, state_d;
    job_t                job_q, job_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    rd_k_q, rd_k_d;
    logic [15:0]         wait_q, wait_d;
    logic [INSTR_W-1:0]  acc_instr_q, acc_instr_d;
    logic                res_valid_q, res_valid_d;
    logic [INSTR_W-1:0]  res_data_q, res_data_d;

    logic                issue;
    opcode_t             op_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [DATA_W-1:0]   data_s;
    logic [INSTR_W-1:0]  word_s;

    logic in_load, din_hs, load_last, wait_done, read_done, last_read;

    assign in_load   = (state_q == S_LOAD_INP) || (state_q == S_LOAD_WT);
    assign din_hs    = in_load && bus.din_valid;
    assign load_last = (idx_q == job_q.len - LEN_W'(1));
    assign wait_done = (wait_q == CW_LAST);
    // Result lands RD_LAT cycles after READ_OUT is visible; sample in that cycle.
    assign read_done = (wait_q == RD_LAST);
    assign last_read = (rd_k_q == job_q.out_cnt - CNT_W'(1));

    accel_host_driver_instr_pack u_pack (
        .op_i   (op_s),
        .addr_i (addr_s),
        .data_i (data_s),
        .word_o (word_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (bus.job_valid) state_d = S_ACC_RST;
            S_ACC_RST:    state_d = (job_q.len == '0) ? S_COMPUTE : S_LOAD_INP;
            S_LOAD_INP:   if (din_hs && load_last) state_d = S_LOAD_WT;
            S_LOAD_WT:    if (din_hs && load_last) state_d = S_COMPUTE;
            S_COMPUTE:    state_d = S_COMP_WAIT;
            S_COMP_WAIT:  if (wait_done)
                              state_d = (job_q.out_cnt == '0) ? S_IDLE : S_READ_ISSUE;
            S_READ_ISSUE: state_d = S_READ_WAIT;
            S_READ_WAIT:  if (read_done) state_d = S_RES_HOLD;
            S_RES_HOLD:   if (bus.res_ready)
                              state_d = last_read ? S_IDLE : S_READ_ISSUE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        job_d       = job_q;
        idx_d       = idx_q;
        rd_k_d      = rd_k_q;
        wait_d      = wait_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        issue       = 1'b0;
        op_s        = OP_NOP;
        addr_s      = '0;
        data_s      = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.job_valid) begin
                    job_d.inp_base = bus.job_inp_base;
                    job_d.wt_base  = bus.job_wt_base;
                    job_d.len      = bus.job_len;
                    job_d.out_cnt  = clip_out_cnt(bus.job_out_cnt);
                    idx_d          = '0;
                    rd_k_d         = '0;
                    wait_d         = '0;
                end
            end
            S_ACC_RST: begin
                issue = 1'b1;
                op_s  = OP_ACC_RESET;
            end
            S_LOAD_INP, S_LOAD_WT: begin
                if (din_hs) begin
                    issue  = 1'b1;
                    op_s   = (state_q == S_LOAD_INP) ? OP_LOAD_INP : OP_LOAD_WT;
                    addr_s = ((state_q == S_LOAD_INP) ? job_q.inp_base : job_q.wt_base)
                             + ADDR_W'(idx_q);
                    data_s = bus.din_data;
                    idx_d  = load_last ? '0 : idx_q + LEN_W'(1);
                end
            end
            S_COMPUTE: begin
                issue  = 1'b1;
                op_s   = OP_COMPUTE;
                wait_d = '0;
            end
            S_COMP_WAIT: wait_d = wait_done ? '0 : wait_q + 16'd1;
            S_READ_ISSUE: begin
                issue  = 1'b1;
                op_s   = OP_READ_OUT;
                addr_s = ADDR_W'(rd_k_q[IDX_W-1:0]);
                wait_d = '0;
            end
            S_READ_WAIT: begin
                if (read_done) begin
                    res_data_d  = bus.acc_result;
                    res_valid_d = 1'b1;
                    wait_d      = '0;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_RES_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    rd_k_d      = rd_k_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign acc_instr_d = issue ? word_s : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_q       <= '0;
            idx_q       <= '0;
            rd_k_q      <= '0;
            wait_q      <= '0;
            acc_instr_q <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            job_q       <= job_d;
            idx_q       <= idx_d;
            rd_k_q      <= rd_k_d;
            wait_q      <= wait_d;
            acc_instr_q <= acc_instr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.job_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.din_ready = in_load;
    assign bus.acc_instr = acc_instr_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_accel_host_driver.sv
// Scoreboard bench for accel_host_driver: expected instructions/results are
// queued as stimulus is issued; a negedge monitor pops and compares.
module tb_accel_host_driver;
    import accel_isa_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accel_host_driver_if bus();

    accel_host_driver #(.ARR_SIZE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] w;
        int          gap;
    } exp_t;

    exp_t        iq[$];
    logic [63:0] rq[$];
    int checks = 0, errors = 0, nop_cnt = 0, res_hs = 0;
    bit din_seen = 1'b0;
    logic [63:0] rd_dly;

    localparam logic [63:0] W_RST  = 64'h5000_0000_0000_0000;
    localparam logic [63:0] W_COMP = 64'h3000_0000_0000_0000;

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [14:0] a,
                                       input logic [31:0] d);
        return {op, a, 13'b0, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_i(input logic [63:0] w, input int gap);
        exp_t e;
        e.w = w;
        e.gap = gap;
        iq.push_back(e);
    endtask

    // Accelerator model: READ_OUT k returns 0x1111*(k+1) RD_LAT=2 cycles later.
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_dly <= '0;
            bus.acc_result <= '0;
        end else begin
            rd_dly <= bus.acc_instr;
            if (rd_dly[63:60] == 4'd4)
                bus.acc_result <= 64'h1111 * ({60'b0, rd_dly[48:45]} + 64'd1);
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            nop_cnt = 0;
            continue;
        end
        if (bus.din_ready) din_seen = 1'b1;
        if (bus.acc_instr != 64'd0) begin
            if (iq.size() == 0) begin
                checks++; errors++;
                $display("FAIL instr_unexpected: got %h want none", bus.acc_instr);
            end else begin
                e = iq.pop_front();
                chk("instr", bus.acc_instr, e.w);
                if (e.gap >= 0) chk("instr_gap", 64'(nop_cnt), 64'(e.gap));
            end
            nop_cnt = 0;
        end else begin
            nop_cnt++;
        end
        if (bus.res_valid) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL result_unexpected: got %h want none", bus.res_data);
            end else if (bus.res_ready) begin
                chk("result", bus.res_data, rq.pop_front());
                res_hs++;
            end else begin
                chk("result_hold", bus.res_data, rq[0]);
            end
        end
    end

    task automatic submit(input logic [14:0] ib, input logic [14:0] wb,
                          input logic [7:0] len, input logic [4:0] oc);
        int n = 0;
        bus.job_inp_base = ib;
        bus.job_wt_base  = wb;
        bus.job_len      = len;
        bus.job_out_cnt  = oc;
        bus.job_valid    = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.job_ready && n < 500);
        if (!bus.job_ready) begin
            checks++; errors++;
            $display("FAIL job_accept_timeout: got busy want job_ready");
        end
        @(posedge clk); #1;
        bus.job_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        int n = 0;
        bus.din_valid = 1'b1;
        bus.din_data  = d;
        do begin @(negedge clk); n++; end while (!bus.din_ready && n < 200);
        if (!bus.din_ready) begin
            checks++; errors++;
            $display("FAIL din_timeout: got din_ready=0 want 1");
        end
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (bus.busy && n < 2000);
        if (bus.busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy=1 want 0");
        end
    endtask

    task automatic wait_cond_hs(input int target);
        int n = 0;
        while (res_hs < target && n < 500) begin @(posedge clk); #1; n++; end
        if (res_hs < target) begin
            checks++; errors++;
            $display("FAIL res_hs_timeout: got %0d want %0d", res_hs, target);
        end
    endtask

    initial begin
        int n;
        bus.job_valid = 1'b1;
        bus.job_inp_base = '0; bus.job_wt_base = '0;
        bus.job_len = 8'd0; bus.job_out_cnt = 5'd1;
        bus.din_valid = 1'b0; bus.din_data = '0;
        bus.res_ready = 1'b1;

        // Reset with job_valid held high
        repeat (3) @(posedge clk); #1;
        chk("rst_acc_instr", bus.acc_instr, 64'd0);
        chk("rst_job_ready", 64'(bus.job_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_din_ready", 64'(bus.din_ready), 64'd0);
        chk("rst_res_data", bus.res_data, 64'd0);
        push_i(W_RST, -1); push_i(W_COMP, 0); push_i(mk(4'd4, 15'd0, 32'd0), 12);
        rq.push_back(64'h1111);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.job_valid = 1'b0;
        wait_idle();

        // Basic job with hand-computed instruction words
        submit(15'h0010, 15'h0100, 8'd2, 5'd1);
        push_i(W_RST, -1);
        push_i(64'h1002_0000_0000_000A, 0);
        push_i(64'h1002_2000_0000_000B, 0);
        push_i(64'h2020_0000_0000_000C, 0);
        push_i(64'h2020_2000_0000_000D, 0);
        push_i(W_COMP, 0);
        push_i(64'h4000_0000_0000_0000, 12);
        rq.push_back(64'h1111);
        send(32'hA); send(32'hB); send(32'hC); send(32'hD);
        wait_idle();

        // 3-cycle din gap mid LOAD_INP, plus address wrap at 0x7FFF
        submit(15'h7FFF, 15'h0001, 8'd2, 5'd0);
        push_i(W_RST, -1);
        push_i(64'h1FFF_E000_0000_0001, 0);
        push_i(64'h1000_0000_0000_0002, 3);
        push_i(64'h2000_2000_0000_0003, 0);
        push_i(64'h2000_4000_0000_0004, 0);
        push_i(W_COMP, 0);
        send(32'h1);
        repeat (3) @(posedge clk); #1;
        send(32'h2); send(32'h3); send(32'h4);
        wait_idle();

        // Three results, res_ready stalled on the second; job_valid while busy
        res_hs = 0;
        submit(15'h0, 15'h0, 8'd0, 5'd3);
        push_i(W_RST, -1); push_i(W_COMP, 0);
        push_i(64'h4000_0000_0000_0000, 12);
        push_i(64'h4000_2000_0000_0000, 4);
        push_i(64'h4000_4000_0000_0000, -1);
        rq.push_back(64'h1111); rq.push_back(64'h2222); rq.push_back(64'h3333);
        bus.job_valid = 1'b1;
        wait_cond_hs(1);
        bus.job_valid = 1'b0;
        bus.res_ready = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.res_valid && n < 100);
        repeat (5) @(posedge clk); #1;
        bus.res_ready = 1'b1;
        wait_idle();
        chk("stall_result_count", 64'(res_hs), 64'd3);

        // len=0, out_cnt=0: no loads, no reads, exact compute wait
        din_seen = 1'b0;
        submit(15'h0123, 15'h0456, 8'd0, 5'd0);
        push_i(W_RST, -1); push_i(W_COMP, 0);
        n = 0;
        while (bus.acc_instr != W_COMP && n < 50) begin @(posedge clk); #1; n++; end
        n = 0;
        do begin @(posedge clk); #1; n++; end while (bus.busy && n < 100);
        chk("comp_wait_cycles", 64'(n), 64'd12);
        chk("din_ready_never", 64'(din_seen), 64'd0);

        // out_cnt above 16 clips to 16 reads
        res_hs = 0;
        submit(15'h0040, 15'h0050, 8'd1, 5'd17);
        push_i(W_RST, -1);
        push_i(mk(4'd1, 15'h0040, 32'h55), 0);
        push_i(mk(4'd2, 15'h0050, 32'h66), 0);
        push_i(W_COMP, 0);
        for (int k = 0; k < 16; k++) begin
            push_i(mk(4'd4, 15'(k), 32'd0), (k == 0) ? 12 : 4);
            rq.push_back(64'h1111 * 64'(k + 1));
        end
        send(32'h55); send(32'h66);
        wait_idle();
        chk("clip_result_count", 64'(res_hs), 64'd16);

        // Reset pulse during LOAD_WT aborts; next job uses its own bases
        submit(15'h0020, 15'h0030, 8'd2, 5'd1);
        push_i(W_RST, -1);
        push_i(mk(4'd1, 15'h0020, 32'hE1), 0);
        push_i(mk(4'd1, 15'h0021, 32'hE2), 0);
        push_i(mk(4'd2, 15'h0030, 32'hE3), 0);
        send(32'hE1); send(32'hE2); send(32'hE3);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_acc_instr", bus.acc_instr, 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_job_ready", 64'(bus.job_ready), 64'd1);
        chk("abort_pending_instr", 64'(iq.size()), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        submit(15'h0200, 15'h0300, 8'd1, 5'd1);
        push_i(W_RST, -1);
        push_i(mk(4'd1, 15'h0200, 32'h77), 0);
        push_i(mk(4'd2, 15'h0300, 32'h88), 0);
        push_i(W_COMP, 0);
        push_i(mk(4'd4, 15'd0, 32'd0), 12);
        rq.push_back(64'h1111);
        send(32'h77); send(32'h88);
        wait_idle();
        repeat (3) @(posedge clk); #1;

        chk("instr_queue_drained", 64'(iq.size()), 64'd0);
        chk("result_queue_drained", 64'(rq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
